aes_round_ctrl: RTL and testbench

AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

---
 rtl/aes_round_ctrl.sv | 99 +++++++++
 tb/tb_aes_round_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_ctrl.sv
// Iterative AES round sequencer: one round per cycle through an external datapath.
// Define AES_CTRL_PERF_CNT_EN to enable the completed-block counter on blk_count.
module aes_round_ctrl #(
    parameter int NK = 4,
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         abort,
    output logic [3:0]   round_idx,
    input  logic [127:0] rk,
    output logic [127:0] rnd_state,
    output logic         rnd_last,
    input  logic [127:0] rnd_result,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic [31:0]  blk_count
);
    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    localparam logic [3:0] LAST = 4'(NR);
    localparam bit CFG_OK = (NK == 4 || NK == 6 || NK == 8) && (NR == NK + 6);

    if (!CFG_OK) begin : g_bad_cfg
        $error("aes_round_ctrl: NK must be 4/6/8 and NR must equal NK+6");
    end

    state_t       state;
    logic [127:0] st;
    logic [3:0]   r;
    logic         in_round;

    assign in_round  = (state == ROUND);
    assign round_idx = in_round ? r : 4'd0;
    assign rnd_state = st;
    assign rnd_last  = in_round && (r == LAST);
    assign out_data  = out_valid ? st : '0;

    always_ff @(posedge clk) begin
        if (reset || abort) begin
            state     <= IDLE;
            st        <= '0;
            r         <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        st       <= in_data ^ rk;
                        r        <= 4'd1;
                        state    <= ROUND;
                        in_ready <= 1'b0;
                    end
                end
                ROUND: begin
                    st <= rnd_result;
                    // r parks at 0 after the final round so it never passes NR
                    if (r == LAST) begin
                        r         <= '0;
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        r <= r + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef AES_CTRL_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            blk_count <= '0;
        end else if (out_valid && out_ready) begin
            blk_count <= blk_count + 32'd1;
        end
    end
`else
    assign blk_count = '0;
`endif

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: AES-128 and AES-256 controllers driving a behavioural
// round datapath and key schedule, with a queue scoreboard of expected ciphertexts.
module tb_aes_round_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  reset;
    logic [1:0]            in_valid, in_ready, abort, rnd_last, out_valid, out_ready;
    logic [1:0][127:0]     in_data, rk, rnd_state, rnd_result, out_data;
    logic [1:0][3:0]       round_idx;
    logic [1:0][31:0]      blk_count;
    logic [127:0]          rks [2][16];
    logic [127:0]          sb0[$];
    logic [127:0]          sb1[$];
    int                    checks = 0;
    int                    errors = 0;
    int                    exp_cnt [2];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = '0; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] x, v;
        x = b; v = 8'h01;
        for (int i = 1; i < 8; i++) begin
            x = gmul(x, x);
            v = gmul(v, x);
        end
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]}
                 ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s,
                                               input logic [127:0] k,
                                               input logic last);
        logic [7:0]   a [16];
        logic [7:0]   b [16];
        logic [7:0]   x0, x1, x2, x3, t;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) a[i] = sbox(s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++) b[rr+4*c] = a[rr+4*((c+rr)%4)];
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                x0 = b[4*c]; x1 = b[4*c+1]; x2 = b[4*c+2]; x3 = b[4*c+3];
                t = x0 ^ x1 ^ x2 ^ x3;
                b[4*c]   = x0 ^ t ^ gmul(x0 ^ x1, 8'h02);
                b[4*c+1] = x1 ^ t ^ gmul(x1 ^ x2, 8'h02);
                b[4*c+2] = x2 ^ t ^ gmul(x2 ^ x3, 8'h02);
                b[4*c+3] = x3 ^ t ^ gmul(x3 ^ x0, 8'h02);
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = b[i];
        return o ^ k;
    endfunction

    function automatic logic [127:0] aes_enc(input bit d, input logic [127:0] pt);
        logic [127:0] s;
        int nr;
        nr = d ? 14 : 10;
        s = pt ^ rks[d][0];
        for (int i = 1; i <= nr; i++) s = aes_round(s, rks[d][i], i == nr);
        return s;
    endfunction

    task automatic expand(input bit d, input int nk, input logic [255:0] key);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 60; i++) w[i] = '0;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nk+7); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = subword(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int j = 0; j < 16; j++) rks[d][j] = '0;
        for (int j = 0; j < nk + 7; j++)
            rks[d][j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
    endtask

    assign rk[0] = rks[0][round_idx[0]];
    assign rk[1] = rks[1][round_idx[1]];
    assign rnd_result[0] = aes_round(rnd_state[0], rk[0], rnd_last[0]);
    assign rnd_result[1] = aes_round(rnd_state[1], rk[1], rnd_last[1]);

    aes_round_ctrl #(.NK(4), .NR(10)) dut4 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
        .abort(abort[0]), .round_idx(round_idx[0]), .rk(rk[0]),
        .rnd_state(rnd_state[0]), .rnd_last(rnd_last[0]), .rnd_result(rnd_result[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
        .blk_count(blk_count[0])
    );

    aes_round_ctrl #(.NK(8), .NR(14)) dut8 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
        .abort(abort[1]), .round_idx(round_idx[1]), .rk(rk[1]),
        .rnd_state(rnd_state[1]), .rnd_last(rnd_last[1]), .rnd_result(rnd_result[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
        .blk_count(blk_count[1])
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input bit d, input logic [127:0] v);
        if (d) sb1.push_back(v);
        else sb0.push_back(v);
    endtask

    task automatic pop(input bit d, output logic [127:0] v);
        int n;
        n = d ? sb1.size() : sb0.size();
        check("sb_nonempty", 128'(n > 0), 128'd1);
        v = 'x;
        if (n > 0) v = d ? sb1.pop_front() : sb0.pop_front();
    endtask

    task automatic count_done(input bit d);
`ifdef AES_CTRL_PERF_CNT_EN
        exp_cnt[d]++;
`endif
        check("blk_count", 128'(blk_count[d]), 128'(exp_cnt[d]));
    endtask

    task automatic run_block(input bit d, input logic [127:0] data,
                             input logic [127:0] exp, input int stall);
        int n, nr;
        logic [127:0] v;
        nr = d ? 14 : 10;
        n = 0;
        while (!in_ready[d] && n < 20) begin step(); n++; end
        check("accept_wait", 128'(in_ready[d]), 128'd1);
        in_valid[d] = 1'b1; in_data[d] = data; push(d, exp);
        step();
        in_valid[d] = 1'b0; in_data[d] = '0;
        n = 1;
        while (!out_valid[d] && n < 40) begin
            if (n <= nr) begin
                check("round_idx", 128'(round_idx[d]), 128'(n));
                check("rnd_last", 128'(rnd_last[d]), 128'(n == nr));
                check("busy_in_ready", 128'(in_ready[d]), 128'd0);
            end
            step(); n++;
        end
        check("latency", 128'(n), 128'(nr + 1));
        pop(d, v);
        for (int s = 0; s < stall; s++) begin
            check("stall_valid", 128'(out_valid[d]), 128'd1);
            check("stall_data", out_data[d], v);
            check("stall_in_ready", 128'(in_ready[d]), 128'd0);
            step();
        end
        out_ready[d] = 1'b1;
        check("out_data", out_data[d], v);
        check("out_valid", 128'(out_valid[d]), 128'd1);
        step();
        out_ready[d] = 1'b0;
        check("idle_in_ready", 128'(in_ready[d]), 128'd1);
        check("idle_out_valid", 128'(out_valid[d]), 128'd0);
        check("idle_out_data", out_data[d], 128'd0);
        count_done(d);
    endtask

    initial begin
        logic [127:0] pt, v;
        int seen, cyc, nacc, nout, last_acc;
        bit acc;
        reset = 1'b1;
        in_valid = '0; abort = '0; out_ready = '0; in_data = '0;
        exp_cnt[0] = 0; exp_cnt[1] = 0;
        expand(1'b0, 4, {128'h000102030405060708090a0b0c0d0e0f, 128'h0});
        expand(1'b1, 8, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
        pt = 128'h00112233445566778899aabbccddeeff;
        step(); step();
        reset = 1'b0;
        step();

        check("rst_in_ready", 128'(in_ready[0]), 128'd1);
        check("rst_out_valid", 128'(out_valid[0]), 128'd0);
        check("rst_out_data", out_data[0], 128'd0);
        check("rst_round_idx", 128'(round_idx[0]), 128'd0);
        check("rst_rnd_last", 128'(rnd_last[0]), 128'd0);
        check("rst_rnd_state", rnd_state[0], 128'd0);
        check("rst_blk_count", 128'(blk_count[0]), 128'd0);
        check("rst_in_ready8", 128'(in_ready[1]), 128'd1);

        run_block(1'b0, pt, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 0);
        run_block(1'b1, pt, 128'h8ea2b7ca516745bfeafc49904b496089, 0);

        v = {$urandom, $urandom, $urandom, $urandom};
        run_block(1'b0, v, aes_enc(1'b0, v), 5);

        // abort in the middle of round 4
        in_valid[0] = 1'b1; in_data[0] = pt;
        step();
        in_valid[0] = 1'b0;
        step(); step(); step();
        check("abort_at_r4", 128'(round_idx[0]), 128'd4);
        abort[0] = 1'b1;
        step();
        abort[0] = 1'b0;
        check("abort_in_ready", 128'(in_ready[0]), 128'd1);
        check("abort_out_valid", 128'(out_valid[0]), 128'd0);
        check("abort_round_idx", 128'(round_idx[0]), 128'd0);
        check("abort_st_clear", rnd_state[0], 128'd0);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            if (out_valid[0]) seen++;
            step();
        end
        check("abort_no_output", 128'(seen), 128'd0);

        // abort wins over a simultaneous input offer
        abort[0] = 1'b1; in_valid[0] = 1'b1; in_data[0] = pt;
        step();
        abort[0] = 1'b0; in_valid[0] = 1'b0;
        check("abort_prio_idx", 128'(round_idx[0]), 128'd0);
        check("abort_prio_ready", 128'(in_ready[0]), 128'd1);

        v = {$urandom, $urandom, $urandom, $urandom};
        run_block(1'b0, v, aes_enc(1'b0, v), 0);

        // abort while holding a finished block
        in_valid[0] = 1'b1; in_data[0] = pt;
        step();
        in_valid[0] = 1'b0;
        cyc = 0;
        while (!out_valid[0] && cyc < 40) begin step(); cyc++; end
        check("done_reached", 128'(out_valid[0]), 128'd1);
        abort[0] = 1'b1;
        step();
        abort[0] = 1'b0;
        check("done_abort_valid", 128'(out_valid[0]), 128'd0);
        check("done_abort_data", out_data[0], 128'd0);
        check("done_abort_ready", 128'(in_ready[0]), 128'd1);
        check("done_abort_cnt", 128'(blk_count[0]), 128'(exp_cnt[0]));

        // reset (with abort also high) during ROUND
        in_valid[0] = 1'b1; in_data[0] = pt;
        step();
        in_valid[0] = 1'b0;
        step(); step(); step(); step();
        reset = 1'b1; abort[0] = 1'b1;
        step();
        reset = 1'b0; abort[0] = 1'b0;
        exp_cnt[0] = 0; exp_cnt[1] = 0;
        check("mid_rst_in_ready", 128'(in_ready[0]), 128'd1);
        check("mid_rst_out_valid", 128'(out_valid[0]), 128'd0);
        check("mid_rst_out_data", out_data[0], 128'd0);
        check("mid_rst_round_idx", 128'(round_idx[0]), 128'd0);
        check("mid_rst_rnd_state", rnd_state[0], 128'd0);
        check("mid_rst_blk_count", 128'(blk_count[0]), 128'd0);
        check("mid_rst_blk_count8", 128'(blk_count[1]), 128'd0);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            if (out_valid[0]) seen++;
            step();
        end
        check("rst_no_output", 128'(seen), 128'd0);

        // three back-to-back blocks with the consumer always ready
        out_ready[0] = 1'b1;
        in_valid[0] = 1'b1;
        in_data[0] = {$urandom, $urandom, $urandom, $urandom};
        nacc = 0; nout = 0; last_acc = 0; cyc = 0;
        while (nout < 3 && cyc < 200) begin
            acc = in_valid[0] && in_ready[0];
            if (acc) begin
                push(1'b0, aes_enc(1'b0, in_data[0]));
                if (nacc > 0) check("b2b_spacing", 128'(cyc - last_acc), 128'd12);
                last_acc = cyc;
                nacc++;
            end
            if (out_valid[0]) begin
                pop(1'b0, v);
                check("b2b_data", out_data[0], v);
                nout++;
`ifdef AES_CTRL_PERF_CNT_EN
                exp_cnt[0]++;
`endif
            end
            step();
            cyc++;
            if (nacc == 3) in_valid[0] = 1'b0;
            else if (acc) in_data[0] = {$urandom, $urandom, $urandom, $urandom};
        end
        out_ready[0] = 1'b0;
        in_valid[0] = 1'b0;
        check("b2b_outputs", 128'(nout), 128'd3);
        check("b2b_blk_count", 128'(blk_count[0]), 128'(exp_cnt[0]));
        check("b2b_blk_count8", 128'(blk_count[1]), 128'(exp_cnt[1]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
